// File: rtl/odev2_eval_pipe.sv
// Bitwise logic evaluator with a DEPTH-word FIFO output buffer (one-cycle latency).
// Optional macro ODEV_POPCNT_EN adds the f_ones running popcount of popped f words.

module odev2_eval_lane (
    input  logic a_i,
    input  logic b_i,
    input  logic c_i,
    output logic f_o,
    output logic q_o
);
    logic x, n, o;

    // q is deliberately left unsimplified even though it is constant zero
    assign x   = (~a_i) ^ b_i;
    assign n   = ~(b_i & c_i);
    assign o   = (~c_i) | b_i;
    assign f_o = ~(x ^ n);
    assign q_o = ~(x | n | o);
endmodule

module odev2_eval_pipe #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [WIDTH-1:0]         a,
    input  logic [WIDTH-1:0]         b,
    input  logic [WIDTH-1:0]         c,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [WIDTH-1:0]         f,
    output logic [WIDTH-1:0]         q,
    output logic [$clog2(DEPTH):0]   level
`ifdef ODEV_POPCNT_EN
    ,
    output logic [15:0]              f_ones
`endif
);
    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    typedef struct packed {
        logic [WIDTH-1:0] f;
        logic [WIDTH-1:0] q;
    } word_t;

    word_t            wr_word;
    word_t            mem_q [DEPTH];
    logic [AW-1:0]    wptr_q, wptr_d;
    logic [AW-1:0]    rptr_q, rptr_d;
    logic [LW-1:0]    level_q, level_d;
    logic             push, pop;

    for (genvar i = 0; i < WIDTH; i++) begin : g_lane
        odev2_eval_lane u_lane (
            .a_i (a[i]),
            .b_i (b[i]),
            .c_i (c[i]),
            .f_o (wr_word.f[i]),
            .q_o (wr_word.q[i])
        );
    end

    // No bypass: a full buffer refuses input even if the head pops this cycle
    assign in_ready  = (level_q < LW'(DEPTH));
    assign out_valid = (level_q != '0);
    assign push      = in_valid & in_ready;
    assign pop       = out_valid & out_ready;

    assign f     = mem_q[rptr_q].f;
    assign q     = mem_q[rptr_q].q;
    assign level = level_q;

    always_comb begin
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        level_d = level_q;
        if (push) wptr_d = wptr_q + AW'(1);
        if (pop)  rptr_d = rptr_q + AW'(1);
        case ({push, pop})
            2'b10:   level_d = level_q + LW'(1);
            2'b01:   level_d = level_q - LW'(1);
            default: level_d = level_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            level_q <= '0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            level_q <= level_d;
        end
    end

    // Storage is intentionally not reset; pointers alone define validity
    always_ff @(posedge clk) begin
        if (push && !rst) mem_q[wptr_q] <= wr_word;
    end

`ifdef ODEV_POPCNT_EN
    logic [15:0] f_ones_q, f_ones_d;
    logic [16:0] pop_cnt;
    logic [16:0] sum;

    always_comb begin
        pop_cnt = '0;
        for (int i = 0; i < WIDTH; i++) begin
            pop_cnt = pop_cnt + {16'd0, f[i]};
        end
        sum      = {1'b0, f_ones_q} + pop_cnt;
        f_ones_d = f_ones_q;
        if (pop) f_ones_d = (sum > 17'h0FFFF) ? 16'hFFFF : sum[15:0];
    end

    always_ff @(posedge clk) begin
        if (rst) f_ones_q <= '0;
        else     f_ones_q <= f_ones_d;
    end

    assign f_ones = f_ones_q;
`endif

endmodule

// File: doc/odev2_eval_pipe.md
ODEV2_EVAL_PIPE -- requirements
Module: odev2_eval_pipe

Interface
REQ-001 The block SHALL take parameter WIDTH, default 8, meaning the number of independent bit lanes per word (>=1).
REQ-002 The block SHALL take parameter DEPTH, default 4, meaning the output buffer depth in words (power of 2, >=2).
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, synchronous and active-high.
REQ-005 in_valid  input  1  input word a/b/c is valid.
REQ-006 in_ready  output  1  block accepts a word this cycle.
REQ-007 a, b, c  input  WIDTH each  operand vectors, one lane per bit.
REQ-008 out_valid  output  1  head word f/q is valid.
REQ-009 out_ready  input  1  consumer takes head word this cycle.
REQ-010 f, q  output  WIDTH each  result vectors of head word.
REQ-011 level  output  clog2(DEPTH)+1  number of words held in buffer.
REQ-012 f_ones  output  16  running count of 1-bits in popped f words (present only with ODEV_POPCNT_EN).

Function
REQ-013 Per lane i: x = (~a[i]) xor b[i]; n = ~(b[i] & c[i]); o = (~c[i]) | b[i]; f[i] = ~(x xor n); q[i] = ~(x | n | o).
REQ-014 q SHALL be implemented from the REQ-013 equations without simplification; q evaluates to all-zero for every input, and the bench SHALL check this.
REQ-015 A push SHALL occur on a cycle with in_valid=1 and in_ready=1; the computed f/q pair is written into the buffer at that edge.
REQ-016 A pop SHALL occur on a cycle with out_valid=1 and out_ready=1; the head word is removed at that edge.
REQ-017 in_ready SHALL equal (level < DEPTH); no bypass: a full buffer refuses input even when a pop occurs the same cycle.
REQ-018 out_valid SHALL equal (level != 0); f/q SHALL show the head word combinationally from buffer storage, and are don't-care while out_valid=0.
REQ-019 Latency SHALL be exactly one cycle: a word pushed into an empty buffer at edge k appears with out_valid=1 after edge k.
REQ-020 Simultaneous push and pop with 0 < level < DEPTH SHALL leave level unchanged and preserve FIFO order.
REQ-021 Read and write pointers SHALL be clog2(DEPTH) bits and wrap modulo DEPTH; order SHALL be strict first-in first-out across wrap-around.
REQ-022 Inputs SHALL be ignored when in_ready=0 or in_valid=0; out_ready SHALL be ignored when out_valid=0.

Reset
REQ-023 With rst=1 at a rising edge: level=0, pointers=0, out_valid=0, in_ready=1 (from the next cycle), f_ones=0; buffer contents are not cleared.
REQ-024 Reset SHALL take priority over a simultaneous push or pop; words in flight are discarded.

Configuration
REQ-025 Macro ODEV_POPCNT_EN defined: f_ones port exists; each pop adds popcount(f) of the popped word; saturates at 16'hFFFF.
REQ-026 ODEV_POPCNT_EN undefined: f_ones port and its counter logic are absent; all other behaviour is identical.

Verification (WIDTH=8, DEPTH=4)
REQ-027 Push a=00, b=00, c=00 into empty buffer -> next cycle out_valid=1, f=FF, q=00, level=1.
REQ-028 Push a=F0, b=CC, c=AA, then a=FF, b=00, c=FF, out_ready=1 -> pops in order f=4B then f=00, q=00 both.
REQ-029 out_ready=0, push 5 consecutive words -> in_ready=0 after 4th push, level=4, 5th word not accepted; then release out_ready -> 4 words pop in order, in_ready=1 after first pop.
REQ-030 Continuous push+pop of 10 words at level=2 -> level stays 2, output order matches input across pointer wrap.
REQ-031 Assert rst with level=3 -> next cycle level=0, out_valid=0, in_ready=1, f_ones=0.
REQ-032 With ODEV_POPCNT_EN: pop two words with f=FF -> f_ones=16; preload near 16'hFFFF -> holds at 16'hFFFF.
